// File: rtl/mac_tx_arbiter.sv
// Shares the MAC transmit engine between the ARP and IP framers one whole frame at a time.
// The winner's stream is muxed through one register stage and its byte count is checked against the declared length.
module mac_tx_arbiter #(
    parameter bit          P_RR_MODE = 1'b1,
    parameter logic [15:0] P_MAX_LEN = 16'd1500
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_arp_req,
    output logic        o_arp_ready,
    input  logic [15:0] i_arp_type,
    input  logic [15:0] i_arp_len,
    input  logic [7:0]  i_arp_data,
    input  logic        i_arp_last,
    input  logic        i_arp_valid,
    input  logic        i_ip_req,
    output logic        o_ip_ready,
    input  logic [15:0] i_ip_type,
    input  logic [15:0] i_ip_len,
    input  logic [7:0]  i_ip_data,
    input  logic        i_ip_last,
    input  logic        i_ip_valid,
    output logic        o_mac_req,
    input  logic        i_mac_ready,
    output logic [15:0] o_mac_type,
    output logic [15:0] o_mac_len,
    output logic [7:0]  o_mac_data,
    output logic        o_mac_last,
    output logic        o_mac_valid,
    output logic [1:0]  o_grant,
    output logic        o_len_err,
    output logic        o_len_refuse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    logic        prefer_ip_r;
    logic [15:0] len_r;
    logic [15:0] cnt_r;
    logic [1:0]  since_req_r;

    logic        pick_ip_s;
    logic [15:0] win_len_s;
    logic        refuse_s;
    logic        start_s;
    logic [15:0] sel_type_s;
    logic [15:0] sel_len_s;
    logic [7:0]  sel_data_s;
    logic        sel_last_s;
    logic        sel_valid_s;

    // Arbitration: choose a winner and judge its declared length.
    always_comb begin
        pick_ip_s = 1'b0;
        if (i_arp_req && i_ip_req) begin
            if (P_RR_MODE) begin
                pick_ip_s = prefer_ip_r;
            end else begin
                pick_ip_s = 1'b0;
            end
        end else if (i_ip_req) begin
            pick_ip_s = 1'b1;
        end else begin
            pick_ip_s = 1'b0;
        end
        win_len_s = pick_ip_s ? i_ip_len : i_arp_len;
        refuse_s  = (win_len_s == 16'd0) || (win_len_s > P_MAX_LEN);
        // A refusal pulse is still visible to the framer this cycle, so its req is stale.
        start_s   = i_mac_ready && (i_arp_req || i_ip_req) && !o_len_refuse;
    end

    // Stream mux selected by the current owner.
    always_comb begin
        if (o_grant[1]) begin
            sel_type_s  = i_ip_type;
            sel_len_s   = i_ip_len;
            sel_data_s  = i_ip_data;
            sel_last_s  = i_ip_last;
            sel_valid_s = i_ip_valid;
        end else begin
            sel_type_s  = i_arp_type;
            sel_len_s   = i_arp_len;
            sel_data_s  = i_arp_data;
            sel_last_s  = i_arp_last;
            sel_valid_s = i_arp_valid;
        end
    end

    // Frame FSM with registered handshake, stream and status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            prefer_ip_r  <= 1'b0;
            len_r        <= 16'd0;
            cnt_r        <= 16'd0;
            since_req_r  <= 2'd0;
            o_arp_ready  <= 1'b0;
            o_ip_ready   <= 1'b0;
            o_mac_req    <= 1'b0;
            o_mac_type   <= 16'd0;
            o_mac_len    <= 16'd0;
            o_mac_data   <= 8'd0;
            o_mac_last   <= 1'b0;
            o_mac_valid  <= 1'b0;
            o_grant      <= 2'b00;
            o_len_err    <= 1'b0;
            o_len_refuse <= 1'b0;
        end else begin
            o_arp_ready  <= 1'b0;
            o_ip_ready   <= 1'b0;
            o_mac_req    <= 1'b0;
            o_len_err    <= 1'b0;
            o_len_refuse <= 1'b0;
            if (since_req_r != 2'd3) begin
                since_req_r <= since_req_r + 2'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    o_mac_type  <= 16'd0;
                    o_mac_len   <= 16'd0;
                    o_mac_data  <= 8'd0;
                    o_mac_last  <= 1'b0;
                    o_mac_valid <= 1'b0;
                    if (start_s) begin
                        prefer_ip_r <= ~pick_ip_s;
                        o_arp_ready <= ~pick_ip_s;
                        o_ip_ready  <= pick_ip_s;
                        if (refuse_s) begin
                            o_len_refuse <= 1'b1;
                        end else begin
                            o_grant     <= pick_ip_s ? 2'b10 : 2'b01;
                            len_r       <= win_len_s;
                            o_mac_req   <= 1'b1;
                            since_req_r <= 2'd0;
                            state_r     <= ST_GRANT;
                        end
                    end
                end
                ST_GRANT: begin
                    cnt_r   <= 16'd0;
                    state_r <= ST_XFER;
                end
                ST_XFER: begin
                    o_mac_type  <= sel_type_s;
                    o_mac_len   <= sel_len_s;
                    o_mac_data  <= sel_data_s;
                    o_mac_last  <= sel_last_s;
                    o_mac_valid <= sel_valid_s;
                    if (sel_valid_s) begin
                        cnt_r <= cnt_r + 16'd1;
                        if (sel_last_s) begin
                            o_len_err <= ((cnt_r + 16'd1) != len_r);
                            state_r   <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    o_mac_type  <= 16'd0;
                    o_mac_len   <= 16'd0;
                    o_mac_data  <= 8'd0;
                    o_mac_last  <= 1'b0;
                    o_mac_valid <= 1'b0;
                    // The MAC only lowers ready a cycle after req, so its ready is meaningless before then.
                    if (i_mac_ready && (since_req_r >= 2'd2)) begin
                        o_grant <= 2'b00;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    o_grant <= 2'b00;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: a round-robin and a fixed-priority instance share stimulus,
// frame records are served from a table, and refusal, stall and reset corners are hand-written.
module tb_mac_tx_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        arp_req, arp_last, arp_valid, ip_req, ip_last, ip_valid, mac_ready;
    logic [15:0] arp_type, arp_len, ip_type, ip_len;
    logic [7:0]  arp_data, ip_data;
    bit          use_fix;

    logic        rr_arp_ready, rr_ip_ready, rr_mac_req, rr_mac_last, rr_mac_valid, rr_len_err, rr_len_refuse;
    logic [15:0] rr_mac_type, rr_mac_len;
    logic [7:0]  rr_mac_data;
    logic [1:0]  rr_grant;
    logic        fx_arp_ready, fx_ip_ready, fx_mac_req, fx_mac_last, fx_mac_valid, fx_len_err, fx_len_refuse;
    logic [15:0] fx_mac_type, fx_mac_len;
    logic [7:0]  fx_mac_data;
    logic [1:0]  fx_grant;

    logic        m_arp_ready, m_ip_ready, m_mac_req, m_mac_last, m_mac_valid, m_len_err, m_len_refuse;
    logic [15:0] m_mac_type, m_mac_len;
    logic [7:0]  m_mac_data;
    logic [1:0]  m_grant;

    assign m_arp_ready  = use_fix ? fx_arp_ready  : rr_arp_ready;
    assign m_ip_ready   = use_fix ? fx_ip_ready   : rr_ip_ready;
    assign m_mac_req    = use_fix ? fx_mac_req    : rr_mac_req;
    assign m_mac_type   = use_fix ? fx_mac_type   : rr_mac_type;
    assign m_mac_len    = use_fix ? fx_mac_len    : rr_mac_len;
    assign m_mac_data   = use_fix ? fx_mac_data   : rr_mac_data;
    assign m_mac_last   = use_fix ? fx_mac_last   : rr_mac_last;
    assign m_mac_valid  = use_fix ? fx_mac_valid  : rr_mac_valid;
    assign m_grant      = use_fix ? fx_grant      : rr_grant;
    assign m_len_err    = use_fix ? fx_len_err    : rr_len_err;
    assign m_len_refuse = use_fix ? fx_len_refuse : rr_len_refuse;

    mac_tx_arbiter #(.P_RR_MODE(1'b1), .P_MAX_LEN(16'd1500)) u_rr (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_arp_req(arp_req), .o_arp_ready(rr_arp_ready), .i_arp_type(arp_type), .i_arp_len(arp_len),
        .i_arp_data(arp_data), .i_arp_last(arp_last), .i_arp_valid(arp_valid),
        .i_ip_req(ip_req), .o_ip_ready(rr_ip_ready), .i_ip_type(ip_type), .i_ip_len(ip_len),
        .i_ip_data(ip_data), .i_ip_last(ip_last), .i_ip_valid(ip_valid),
        .o_mac_req(rr_mac_req), .i_mac_ready(mac_ready), .o_mac_type(rr_mac_type), .o_mac_len(rr_mac_len),
        .o_mac_data(rr_mac_data), .o_mac_last(rr_mac_last), .o_mac_valid(rr_mac_valid),
        .o_grant(rr_grant), .o_len_err(rr_len_err), .o_len_refuse(rr_len_refuse)
    );

    mac_tx_arbiter #(.P_RR_MODE(1'b0), .P_MAX_LEN(16'd1500)) u_fx (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_arp_req(arp_req), .o_arp_ready(fx_arp_ready), .i_arp_type(arp_type), .i_arp_len(arp_len),
        .i_arp_data(arp_data), .i_arp_last(arp_last), .i_arp_valid(arp_valid),
        .i_ip_req(ip_req), .o_ip_ready(fx_ip_ready), .i_ip_type(ip_type), .i_ip_len(ip_len),
        .i_ip_data(ip_data), .i_ip_last(ip_last), .i_ip_valid(ip_valid),
        .o_mac_req(fx_mac_req), .i_mac_ready(mac_ready), .o_mac_type(fx_mac_type), .o_mac_len(fx_mac_len),
        .o_mac_data(fx_mac_data), .o_mac_last(fx_mac_last), .o_mac_valid(fx_mac_valid),
        .o_grant(fx_grant), .o_len_err(fx_len_err), .o_len_refuse(fx_len_refuse)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          use_fix;
        bit          raise_arp;
        bit          raise_ip;
        logic [15:0] arp_len;
        logic [15:0] ip_len;
        int          nbytes;
        int          gap_at;
        int          hold;
        logic [1:0]  exp_grant;
        bit          exp_err;
    } vec_t;

    vec_t vecs [12];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        arp_req = 1'b0; ip_req = 1'b0; arp_valid = 1'b0; ip_valid = 1'b0;
        arp_last = 1'b0; ip_last = 1'b0; arp_data = 8'd0; ip_data = 8'd0;
        i_rst = 1'b1;
        tick();
        tick();
        check("reset grant", m_grant, 2'b00);
        check("reset mac_req", m_mac_req, 1'b0);
        check("reset mac_valid", m_mac_valid, 1'b0);
        check("reset readys", {m_arp_ready, m_ip_ready}, 2'b00);
        check("reset flags", {m_len_err, m_len_refuse}, 2'b00);
        i_rst = 1'b0;
        mac_ready = 1'b1;
        tick();
    endtask

    // Waits for the grant, streams v.nbytes bytes from the winner and checks the muxed output stream.
    task automatic serve(input vec_t v, input int seed);
        int          n;
        bit          win_ip;
        logic [7:0]  b;
        logic [15:0] exp_type, exp_len;
        n = 0;
        while (m_mac_req !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("mac_req seen", m_mac_req, 1'b1);
        check("grant owner", m_grant, v.exp_grant);
        check("ready pulse", {m_ip_ready, m_arp_ready}, v.exp_grant);
        win_ip   = v.exp_grant[1];
        exp_type = win_ip ? 16'h0800 : 16'h0806;
        exp_len  = win_ip ? ip_len : arp_len;
        if (win_ip) ip_req = 1'b0; else arp_req = 1'b0;
        mac_ready = 1'b0;
        if (win_ip) begin
            arp_valid = 1'b1; arp_data = 8'h5a; arp_last = 1'b1;
        end else begin
            ip_valid = 1'b1; ip_data = 8'h5a; ip_last = 1'b1;
        end
        tick();
        check("mac_req single", m_mac_req, 1'b0);
        for (int k = 0; k < v.nbytes; k++) begin
            if (k == v.gap_at) begin
                if (win_ip) ip_valid = 1'b0; else arp_valid = 1'b0;
                tick();
                check("gap valid", m_mac_valid, 1'b0);
                check("gap grant", m_grant, v.exp_grant);
            end
            b = 8'(k * 7 + seed);
            if (win_ip) begin
                ip_valid = 1'b1; ip_data = b; ip_last = (k == v.nbytes - 1);
            end else begin
                arp_valid = 1'b1; arp_data = b; arp_last = (k == v.nbytes - 1);
            end
            tick();
            check("byte data", m_mac_data, b);
            check("byte valid", m_mac_valid, 1'b1);
            check("byte last", m_mac_last, (k == v.nbytes - 1));
            if (k == 0 || k == v.nbytes - 1) begin
                check("frame type", m_mac_type, exp_type);
                check("frame len", m_mac_len, exp_len);
            end
            if (k == v.nbytes - 1) check("len_err", m_len_err, v.exp_err);
        end
        arp_valid = 1'b0; arp_last = 1'b0; arp_data = 8'd0;
        ip_valid = 1'b0; ip_last = 1'b0; ip_data = 8'd0;
        tick();
        check("drain zero", {m_mac_valid, m_mac_last, m_mac_data, m_mac_type}, 32'd0);
        check("len_err single", m_len_err, 1'b0);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            check("drain hold grant", m_grant, v.exp_grant);
        end
        mac_ready = 1'b1;
        n = 0;
        while (m_grant !== 2'b00 && n < 10) begin
            tick();
            n++;
        end
        check("grant released", m_grant, 2'b00);
    endtask

    initial begin
        int n;
        bit cur_mode;
        arp_type = 16'h0806; ip_type = 16'h0800; arp_len = 16'd0; ip_len = 16'd0;
        arp_req = 1'b0; ip_req = 1'b0; arp_valid = 1'b0; ip_valid = 1'b0;
        arp_last = 1'b0; ip_last = 1'b0; arp_data = 8'd0; ip_data = 8'd0;
        mac_ready = 1'b0; i_rst = 1'b1; use_fix = 1'b0; cur_mode = 1'b0;

        //          fix  arp  ip   arp_len  ip_len  n     gap  hold grant  err
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'd28, 16'd0,    28,   -1, 0, 2'b01, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'd0,  16'd64,   60,   -1, 1, 2'b10, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'd28, 16'd100,  28,   -1, 0, 2'b01, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'd28, 16'd0,    100,  50, 3, 2'b10, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'd0,  16'd0,    28,   -1, 0, 2'b01, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'd5,  16'd0,    6,    -1, 0, 2'b01, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'd0,  16'd1500, 1500, -1, 0, 2'b10, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'd1,  16'd0,    1,    -1, 2, 2'b01, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 16'd3,  16'd4,    3,    -1, 0, 2'b01, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'd3,  16'd0,    3,    -1, 0, 2'b01, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 16'd3,  16'd0,    3,    2,  0, 2'b01, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0,    4,    -1, 0, 2'b10, 1'b0};

        for (int i = 0; i < 12; i++) begin
            if (i == 0 || vecs[i].use_fix != cur_mode) begin
                cur_mode = vecs[i].use_fix;
                use_fix  = cur_mode;
                do_reset();
            end
            if (vecs[i].raise_arp) begin arp_req = 1'b1; arp_len = vecs[i].arp_len; end
            if (vecs[i].raise_ip)  begin ip_req = 1'b1;  ip_len = vecs[i].ip_len;   end
            serve(vecs[i], i);
        end

        // MAC not ready: a pending request must wait, then win on the first ready cycle.
        use_fix = 1'b0;
        do_reset();
        mac_ready = 1'b0;
        ip_req = 1'b1; ip_len = 16'd8;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("stall no ready", m_ip_ready, 1'b0);
            check("stall no mac_req", m_mac_req, 1'b0);
        end
        mac_ready = 1'b1;
        tick();
        check("stall release grant", m_grant, 2'b10);
        check("stall release req", {m_mac_req, m_ip_ready}, 2'b11);
        serve('{1'b0, 1'b0, 1'b0, 16'd0, 16'd8, 8, -1, 0, 2'b10, 1'b0}, 20);

        // Zero-length refusal still moves the pointer, so the next tie goes to IP.
        arp_req = 1'b1; arp_len = 16'd0;
        n = 0;
        while (m_arp_ready !== 1'b1 && n < 20) begin tick(); n++; end
        check("refuse0 ready", m_arp_ready, 1'b1);
        check("refuse0 pulse", m_len_refuse, 1'b1);
        check("refuse0 no mac_req", {m_mac_req, m_grant}, 3'b000);
        arp_req = 1'b0;
        tick();
        check("refuse0 single", {m_len_refuse, m_arp_ready}, 2'b00);
        arp_req = 1'b1; arp_len = 16'd4; ip_req = 1'b1; ip_len = 16'd4;
        serve('{1'b0, 1'b0, 1'b0, 16'd4, 16'd4, 4, -1, 0, 2'b10, 1'b0}, 21);
        serve('{1'b0, 1'b0, 1'b0, 16'd4, 16'd4, 4, -1, 0, 2'b01, 1'b0}, 22);

        // Oversize refusal.
        ip_req = 1'b1; ip_len = 16'd1600;
        n = 0;
        while (m_ip_ready !== 1'b1 && n < 20) begin tick(); n++; end
        check("refuse1600 ready", m_ip_ready, 1'b1);
        check("refuse1600 pulse", m_len_refuse, 1'b1);
        check("refuse1600 no mac_req", {m_mac_req, m_grant}, 3'b000);
        ip_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("refuse1600 quiet", {m_mac_req, m_len_refuse, m_ip_ready, m_grant}, 5'd0);
        end

        // Asynchronous reset in the middle of a frame.
        arp_req = 1'b1; arp_len = 16'd28;
        n = 0;
        while (m_mac_req !== 1'b1 && n < 20) begin tick(); n++; end
        check("abort mac_req", m_mac_req, 1'b1);
        arp_req = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            arp_valid = 1'b1; arp_data = 8'(8'h30 + k); arp_last = 1'b0;
            tick();
        end
        check("abort streaming", m_mac_valid, 1'b1);
        #2;
        i_rst = 1'b1;
        #1;
        check("abort async zero", {m_mac_valid, m_mac_data, m_mac_type, m_grant}, 32'd0);
        tick();
        check("abort edge zero", {m_mac_valid, m_mac_req, m_arp_ready, m_grant, m_mac_len}, 32'd0);
        arp_valid = 1'b0; arp_data = 8'd0;
        i_rst = 1'b0;
        mac_ready = 1'b1;
        tick();
        tick();
        check("abort idle", m_grant, 2'b00);
        arp_req = 1'b1; arp_len = 16'd2;
        serve('{1'b0, 1'b0, 1'b0, 16'd2, 16'd0, 2, -1, 0, 2'b01, 1'b0}, 23);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
